// File: rtl/and_cascade_pipe_if.sv
// and_cascade_pipe_if: sample/result bundle for the pipelined AND-reduction tree
//   in        operand bits to be AND-reduced (WIDTH)
//   in_valid  qualifies in for this cycle
//   out       AND of all bits of the sample launched LEVELS cycles earlier
//   out_valid in_valid delayed by LEVELS cycles
//   zero_idx  index of lowest-numbered 0 bit (only with AND_CASCADE_ZIDX_EN)
// master drives samples, slave is the reduction tree.
interface and_cascade_pipe_if #(parameter int WIDTH = 8);
  localparam int LEVELS = $clog2(WIDTH);
  logic [WIDTH-1:0] in;
  logic in_valid;
  logic out;
  logic out_valid;
`ifdef AND_CASCADE_ZIDX_EN
  logic [LEVELS-1:0] zero_idx;
  modport master(output in, in_valid, input out, out_valid, zero_idx);
  modport slave(input in, in_valid, output out, out_valid, zero_idx);
`else
  modport master(output in, in_valid, input out, out_valid);
  modport slave(input in, in_valid, output out, out_valid);
`endif
endinterface

// File: rtl/and_cascade_pipe.sv
// and_cascade_pipe: pipelined balanced AND-reduction tree, one register stage per level
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, clears every stage
//   bus    and_cascade_pipe_if.slave: in/in_valid in, out/out_valid (and zero_idx) out
// Optional macro AND_CASCADE_ZIDX_EN adds a parallel priority tree driving bus.zero_idx.
module and_cascade_pipe #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  and_cascade_pipe_if.slave bus
);
  localparam int LEVELS = $clog2(WIDTH);
  logic [LEVELS-1:0] vld;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) vld <= '0;
    else vld <= LEVELS'({vld, bus.in_valid});
  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    // P nodes feed this level, which holds ceil(P/2) = ceil(WIDTH/2^(k+1)) registers
    localparam int P = (WIDTH + (1 << k) - 1) >> k;
    localparam int N = (P + 1) / 2;
    logic [P-1:0] prev;
    logic [N-1:0] node;
`ifdef AND_CASCADE_ZIDX_EN
    logic [LEVELS-1:0] pidx [P];
    logic [LEVELS-1:0] idx [N];
`endif
    if (k == 0) begin : g_in
      assign prev = bus.in;
`ifdef AND_CASCADE_ZIDX_EN
      for (genvar i = 0; i < P; i++) begin : g_leaf
        assign pidx[i] = LEVELS'(i);
      end
`endif
    end else begin : g_up
      assign prev = g_lvl[k-1].node;
`ifdef AND_CASCADE_ZIDX_EN
      assign pidx = g_lvl[k-1].idx;
`endif
    end
    for (genvar j = 0; j < N; j++) begin : g_node
      logic a, b, q;
      assign a = prev[2*j];
      // an unpaired last node is padded with 1 so it cannot force the result low
      if (2*j + 1 < P) begin : g_pair
        assign b = prev[2*j+1];
      end else begin : g_pad
        assign b = 1'b1;
      end
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= 1'b0;
        else q <= a & b;
      assign node[j] = q;
`ifdef AND_CASCADE_ZIDX_EN
      logic [LEVELS-1:0] ib, qi;
      if (2*j + 1 < P) begin : g_ipair
        assign ib = pidx[2*j+1];
      end else begin : g_ipad
        assign ib = '0;
      end
      // lower-index subtree wins when it holds a 0; all-ones subtree reports 0
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) qi <= '0;
        else qi <= !a ? pidx[2*j] : !b ? ib : '0;
      assign idx[j] = qi;
`endif
    end
  end
  assign bus.out = g_lvl[LEVELS-1].node[0];
  assign bus.out_valid = vld[LEVELS-1];
`ifdef AND_CASCADE_ZIDX_EN
  assign bus.zero_idx = g_lvl[LEVELS-1].idx[0];
`endif
endmodule

// File: tb/tb_and_cascade_pipe.sv
// tb_and_cascade_pipe: scoreboard bench for WIDTH=8 and WIDTH=5 AND-reduction trees
module tb_and_cascade_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  and_cascade_pipe_if #(.WIDTH(8)) bus8();
  and_cascade_pipe_if #(.WIDTH(5)) bus5();
  and_cascade_pipe #(.WIDTH(8)) dut8(.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  and_cascade_pipe #(.WIDTH(5)) dut5(.clk(clk), .rst_n(rst_n), .bus(bus5.slave));
  typedef struct {
    int t;
    logic o8;
    logic o5;
    logic [2:0] zi;
  } exp_t;
  exp_t q[$];
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [2:0] zidx(logic [7:0] v);
    logic [2:0] r = '0;
    for (int i = 7; i >= 0; i--) if (!v[i]) r = 3'(i);
    return r;
  endfunction
  task automatic drive(logic [7:0] v, logic vld);
    exp_t e;
    @(negedge clk);
    bus8.in = v;
    bus8.in_valid = vld;
    bus5.in = v[4:0];
    bus5.in_valid = vld;
    if (vld && rst_n) begin
      e.t = cyc + 3;
      e.o8 = &v;
      e.o5 = &v[4:0];
      e.zi = zidx(v);
      q.push_back(e);
    end
  endtask
  exp_t h;
  always @(negedge clk) begin
    if (q.size() != 0 && q[0].t == cyc) begin
      h = q.pop_front();
      check("ov8", bus8.out_valid, 1);
      check("ov5", bus5.out_valid, 1);
      check("out8", bus8.out, h.o8);
      check("out5", bus5.out, h.o5);
`ifdef AND_CASCADE_ZIDX_EN
      check("zidx", bus8.zero_idx, h.zi);
`endif
    end else begin
      check("ov8_idle", bus8.out_valid, 0);
      check("ov5_idle", bus5.out_valid, 0);
    end
  end
  initial begin
    bus8.in = 8'hFF;
    bus8.in_valid = 1'b1;
    bus5.in = 5'h1F;
    bus5.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out8", bus8.out, 0);
    check("rst_out5", bus5.out, 0);
    check("rst_ov8", bus8.out_valid, 0);
    drive(8'h00, 1'b0);
    rst_n = 1'b1;
    drive(8'hFF, 1'b1);
    repeat (6) drive(8'h00, 1'b0);
    for (int i = 0; i < 256; i++) drive(8'(i), 1'b1);
    drive(8'hFE, 1'b1);
    drive(8'h7F, 1'b1);
    drive(8'hFF, 1'b1);
    repeat (4) drive(8'h00, 1'b0);
    drive(8'hF7, 1'b1);
    drive(8'h00, 1'b1);
    drive(8'h1F, 1'b1);
    drive(8'hE0, 1'b1);
    drive(8'h10, 1'b1);
    drive(8'h80, 1'b0);
    for (int i = 0; i < 60; i++)
      drive($urandom_range(0, 2) == 0 ? 8'hFF : 8'hFF ^ (8'd1 << $urandom_range(0, 7)) ^ 8'($urandom_range(0, 1) * $urandom),
            1'($urandom_range(0, 1)));
    repeat (5) drive(8'hFF, 1'b1);
    @(posedge clk);
    #2;
    check("pre_rst_out8", bus8.out, 1);
    check("pre_rst_ov8", bus8.out_valid, 1);
    rst_n = 1'b0;
    q.delete();
    #1;
    check("arst_out8", bus8.out, 0);
    check("arst_out5", bus5.out, 0);
    check("arst_ov8", bus8.out_valid, 0);
    check("arst_ov5", bus5.out_valid, 0);
    drive(8'hFF, 1'b0);
    rst_n = 1'b1;
    repeat (6) drive(8'hFF, 1'b0);
    drive(8'hFF, 1'b1);
    repeat (6) drive(8'h00, 1'b0);
    check("drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
